// File: rtl/fetch_sequencer.sv
// Byte-serial Y86-64 instruction fetch: reads one ROM byte per cycle and assembles icode/ifun/rA/rB/valC/valP.
// Optional FETCH_BOUNDS_CHECK_EN: refuse reads at or above MEM_BYTES and abort with fetch_err.
module fetch_sequencer #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [63:0] PCaddress,
    output logic        fetch_ready,
    output logic        mem_rd,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        fetch_done,
    output logic        fetch_err
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    // Completion is signalled in the cycle the last byte lands, so READ returns straight to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [3:0]  iss_q, iss_d;
    logic        pend_q, pend_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [63:0] valc_q, valc_d;
    logic [63:0] valp_q, valp_d;

    logic        mem_rd_s;
    logic [63:0] mem_addr_s;
    logic        done_s;
    logic        err_s;
    logic [3:0]  cap_s;
    logic [3:0]  len_s;
    logic [3:0]  vbyte_s;
    logic [63:0] rd_addr_s;
    logic        want_s;
    logic        chk_s;

    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
            4'h7, 4'h8:             instr_len = 4'd9;
            4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
            default:                instr_len = 4'd0;
        endcase
    endfunction

    // Next-state, byte capture and read issue.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        iss_d      = iss_q;
        pend_d     = 1'b0;
        len_d      = len_q;
        icode_d    = icode_q;
        ifun_d     = ifun_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        valc_d     = valc_q;
        valp_d     = valp_q;
        mem_rd_s   = 1'b0;
        mem_addr_s = 64'd0;
        done_s     = 1'b0;
        err_s      = 1'b0;
        cap_s      = iss_q - 4'd1;
        len_s      = len_q;
        vbyte_s    = 4'd0;
        rd_addr_s  = pc_q + {60'd0, iss_q};
        want_s     = 1'b0;
        chk_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    pc_d    = PCaddress;
                    iss_d   = 4'd0;
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (pend_q) begin
                    if (cap_s == 4'd0) begin
                        len_s   = instr_len(mem_rdata[7:4]);
                        len_d   = len_s;
                        icode_d = mem_rdata[7:4];
                        ifun_d  = mem_rdata[3:0];
                        ra_d    = 4'hF;
                        rb_d    = 4'hF;
                        valc_d  = 64'd0;
                        valp_d  = pc_q + {60'd0, len_s};
                    end else if ((cap_s == 4'd1) && (len_q != 4'd9)) begin
                        ra_d = mem_rdata[7:4];
                        rb_d = mem_rdata[3:0];
                    end else begin
                        vbyte_s = (len_q == 4'd9) ? (cap_s - 4'd1) : (cap_s - 4'd2);
                        valc_d[{vbyte_s[2:0], 3'b000} +: 8] = mem_rdata;
                    end
                end else begin
                    len_s = len_q;
                end
                // Byte 0 is always issued; the register byte of 2/10-byte forms is exempt from the bounds check.
                want_s = !pend_q || (iss_q < len_s);
                chk_s  = (iss_q != 4'd1) || (len_s == 4'd9);
                if (pend_q && (cap_s == 4'd0) && (len_s == 4'd0)) begin
                    err_s   = 1'b1;
                    state_d = IDLE;
                    ra_d    = 4'h0;
                    rb_d    = 4'h0;
                    valc_d  = 64'd0;
                    valp_d  = 64'd0;
                end else if (want_s) begin
                    if (BOUNDS_EN && chk_s && (rd_addr_s >= 64'(MEM_BYTES))) begin
                        state_d = ERR;
                        icode_d = (iss_q == 4'd0) ? 4'h0 : icode_d;
                        ifun_d  = (iss_q == 4'd0) ? 4'h0 : ifun_d;
                        ra_d    = 4'h0;
                        rb_d    = 4'h0;
                        valc_d  = 64'd0;
                        valp_d  = 64'd0;
                    end else begin
                        mem_rd_s   = 1'b1;
                        mem_addr_s = rd_addr_s;
                        iss_d      = iss_q + 4'd1;
                        pend_d     = 1'b1;
                    end
                end else begin
                    done_s  = 1'b1;
                    state_d = IDLE;
                end
            end
            ERR: begin
                err_s   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and decoded-field registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= 64'd0;
            iss_q   <= 4'd0;
            pend_q  <= 1'b0;
            len_q   <= 4'd0;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= 4'hF;
            rb_q    <= 4'hF;
            valc_q  <= 64'd0;
            valp_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            iss_q   <= iss_d;
            pend_q  <= pend_d;
            len_q   <= len_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
        end
    end

    // The final byte is forwarded so fields are valid alongside the completion pulse.
    assign fetch_ready = (state_q == IDLE);
    assign mem_rd      = mem_rd_s & rst_n;
    assign mem_addr    = mem_addr_s;
    assign fetch_done  = done_s & rst_n;
    assign fetch_err   = err_s & rst_n;
    assign icode       = icode_d;
    assign ifun        = ifun_d;
    assign rA          = ra_d;
    assign rB          = rb_d;
    assign valC        = valc_d;
    assign valP        = valp_d;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction fetch controller for the Y86-64 core. It sits between the PC/decode stage and a byte-wide, synchronous-read instruction ROM. It issues one byte read per cycle, decodes the instruction length from the first byte, and assembles `icode`/`ifun`/`rA`/`rB`/`valC` plus the next-PC `valP`. Decode results are flagged with a one-cycle `fetch_done` pulse, or with `fetch_err` for illegal opcodes and addresses.

## Interface
- `MEM_BYTES`, 1024: ROM size in bytes; used only by the bounds check.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `fetch_req` input 1: request to fetch the instruction at `PCaddress`.
- `PCaddress` input 64: instruction start address, sampled on accept.
- `fetch_ready` output 1: high only in IDLE; accept = `fetch_req & fetch_ready`.
- `mem_rd` output 1: byte read strobe.
- `mem_addr` output 64: byte address of the current read.
- `mem_rdata` input 8: read data, valid the cycle after `mem_rd`.
- `icode`, `ifun`, `rA`, `rB` output 4 each: decoded fields.
- `valC` output 64: little-endian constant.
- `valP` output 64: PC plus instruction length.
- `fetch_done` output 1: one-cycle pulse; outputs are valid.
- `fetch_err` output 1: one-cycle pulse; fetch aborted.

## Operation
- States:
  - IDLE: `fetch_ready`=1. On accept, latch `pc`, set `idx`=0, go to READ.
  - READ: issue bytes.
  - DONE: pulse `fetch_done`, return to IDLE.
  - ERR: pulse `fetch_err`, return to IDLE.
- READ sequencing:
  - First READ cycle: `mem_rd`=1, `mem_addr`=`pc`.
  - Each following cycle captures byte `idx` from `mem_rdata`.
  - It issues byte `idx+1` in the same cycle only if `idx+1` < length.
- Length comes combinationally from byte 0's high nibble:
  - 1 byte: halt 0, nop 1, ret 9.
  - 2 bytes: rrmovq/cmovXX 2, OPq 6, pushq A, popq B.
  - 9 bytes: jXX 7, call 8.
  - 10 bytes: irmovq 3, rmmovq 4, mrmovq 5.
  - icode C–F: go to ERR with no further reads.
- Field capture:
  - Byte 0 gives `icode`/`ifun`.
  - Byte 1 gives `rA`/`rB` for 2- and 10-byte instructions.
  - For 9-byte instructions, bytes 1–8 form `valC`.
  - For 10-byte instructions, bytes 2–9 form `valC`.
  - `valC` byte k goes to `valC[8k+7:8k]`.
- Absent fields: `rA`=`rB`=4'hF and `valC`=0.
- `valP` = `pc` + length, modulo 2^64; PC wrap is not an error.
- Decoded outputs:
  - Hold from the end of each fetch until the next accept.
  - Are undefined while a fetch is in flight.
  - After ERR, `icode`/`ifun` hold the offending byte; other fields are 0.
- `fetch_req` outside IDLE is ignored; no queueing.

## Timing
- Accept at cycle 0 (IDLE).
- For an N-byte instruction, `mem_rd`=1 in cycles 1..N, with `mem_addr` = `pc`+0..`pc`+N−1.
- `fetch_done` pulses in cycle N+1, then IDLE (`fetch_ready`=1) in cycle N+2. Total latency is N+1 cycles.
- Illegal icode: single read in cycle 1, `fetch_err` in cycle 2.
- Back-to-back: the earliest next accept is cycle N+2.
- Reset values:
  - State IDLE, `fetch_ready`=1.
  - `mem_rd`, `fetch_done`, `fetch_err` = 0.
  - `mem_addr`, `valC`, `valP` = 0.
  - `icode`, `ifun` = 0.
  - `rA`, `rB` = 4'hF.
- Reset asserted mid-fetch: the next edge returns to IDLE, with no `fetch_done`/`fetch_err` pulse. A `mem_rdata` value returning after reset is ignored.

## Configuration
- `FETCH_BOUNDS_CHECK_EN` defined:
  - Before issuing any read with address ≥ `MEM_BYTES`, the block goes to ERR instead. No `mem_rd` is issued for that byte.
  - `fetch_err` pulses the following cycle.
  - The check covers byte 0 and every constant byte.
- `FETCH_BOUNDS_CHECK_EN` undefined: addresses pass unchecked to the ROM, and `fetch_err` arises only from illegal icodes.

## Test plan
- Bytes `10` at pc=0: `mem_rd` in cycle 1 only. `fetch_done` in cycle 2 with icode=1, rA=rB=F, valC=0, valP=1.
- irmovq `30 F2 0A 00 00 00 00 00 00 00` at pc=0x10: reads in cycles 1–10, done in cycle 11. icode=3, rA=F, rB=2, valC=10, valP=0x1A.
- call `80 44 33 22 11 00 00 00 00` at pc=0: 9 reads, done in cycle 10. rA=rB=F, valC=0x11223344, valP=9.
- Byte `C0` at pc=5: one read, `fetch_err` in cycle 2, icode=C. `fetch_ready` in cycle 3; a `fetch_req` held during cycles 1–2 is not accepted.
- `rst_n` low in cycle 4 of an irmovq fetch: IDLE and reset values after the edge, no `fetch_done`. A new fetch of `10` then completes normally.
- With the macro and MEM_BYTES=1024, irmovq at pc=1020: reads 1020–1023 issue, no read at 1024. `fetch_err` in cycle 6. Without the macro, the same fetch issues 10 reads and `fetch_done` arrives in cycle 11.
